// File: rtl/raytracing_worker_ms.sv
// Ray/sphere worker: per pixel, tests every sphere, keeps the brightest shade in buffer.
// SHADE cost set by RT_FAST_SHADE_EN (defined: priority encoder; undefined: serial shift).
module raytracing_worker_ms #(
  parameter int JOBS_SUBDIVISION = 8,
  parameter int N_WORKERS        = 4,
  parameter int N_SPHERES        = 2,
  parameter int COLOR_W          = 8,
  parameter int PIXEL_Z          = 100
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                abort,
  input  logic signed [11:0]                  pixel_start_x,
  input  logic signed [11:0]                  pixel_y,
  input  logic signed [N_SPHERES*16-1:0]      sphere_x,
  input  logic signed [N_SPHERES*16-1:0]      sphere_y,
  input  logic signed [N_SPHERES*16-1:0]      sphere_z,
  input  logic        [N_SPHERES*8-1:0]       sphere_r,
  output logic                                busy,
  output logic                                done,
  output logic        [JOBS_SUBDIVISION*COLOR_W-1:0] buffer
);

  localparam int JW    = (JOBS_SUBDIVISION > 1) ? $clog2(JOBS_SUBDIVISION) : 1;
  localparam int SW    = (N_SPHERES > 1) ? $clog2(N_SPHERES) : 1;
  localparam int DIS_W = 72;
  localparam int SMAX  = (1 << COLOR_W) - 1;
  localparam logic signed [35:0] PZ2 = 36'(PIXEL_Z * PIXEL_Z);

  typedef enum logic [2:0] {IDLE, LOAD, CALC1, CALC2, CALC3, CALC4, SHADE, NEXT} state_t;

  state_t                            state_q, state_d;
  logic                              busy_q, busy_d, done_q, done_d;
  logic [JOBS_SUBDIVISION*COLOR_W-1:0] buffer_q, buffer_d;
  logic [JW-1:0]                     job_q, job_d;
  logic [SW-1:0]                     sph_q, sph_d;
  logic [11:0]                       psx_l_q, psx_l_d, py_l_q, py_l_d;
  logic [N_SPHERES*16-1:0]           sx_l_q, sx_l_d, sy_l_q, sy_l_d, sz_l_q, sz_l_d;
  logic [N_SPHERES*8-1:0]            r_l_q, r_l_d;
  logic signed [15:0]                px_q, px_d, py_q, py_d, sx_q, sx_d, sy_q, sy_d, sz_q, sz_d;
  logic [7:0]                        r_q, r_d;
  logic signed [31:0]                pxx_q, pxx_d, pyy_q, pyy_d, sxx_q, sxx_d, syy_q, syy_d;
  logic signed [31:0]                szz_q, szz_d, rr_q, rr_d;
  logic signed [31:0]                pxsx_q, pxsx_d, pysy_q, pysy_d, zsz_q, zsz_d;
  logic signed [35:0]                a_q, a_d, b_q, b_d, c_q, c_d;
  logic signed [DIS_W-1:0]           bb_q, bb_d, ac4_q, ac4_d, dis_q, dis_d;
  logic [COLOR_W-1:0]                shade_q, shade_d;
  logic [15:0]                       px_calc;
  logic [COLOR_W-1:0]                cur_shade;
`ifdef RT_FAST_SHADE_EN
  logic [7:0]                        bitlen;
`else
  logic [7:0]                        cnt_q, cnt_d;
`endif

  // Pixel x wraps at 16 bits by design.
  assign px_calc   = {{4{psx_l_q[11]}}, psx_l_q} + (16'(job_q) * 16'(N_WORKERS));
  assign cur_shade = buffer_q[job_q*COLOR_W +: COLOR_W];

`ifdef RT_FAST_SHADE_EN
  always_comb begin
    bitlen = 8'd0;
    for (int i = 0; i < DIS_W; i++) begin
      if (dis_q[i]) bitlen = 8'(i + 1);
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    buffer_d = buffer_q;
    job_d    = job_q;
    sph_d    = sph_q;
    psx_l_d  = psx_l_q;
    py_l_d   = py_l_q;
    sx_l_d   = sx_l_q;
    sy_l_d   = sy_l_q;
    sz_l_d   = sz_l_q;
    r_l_d    = r_l_q;
    px_d     = px_q;
    py_d     = py_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    sz_d     = sz_q;
    r_d      = r_q;
    pxx_d    = pxx_q;
    pyy_d    = pyy_q;
    sxx_d    = sxx_q;
    syy_d    = syy_q;
    szz_d    = szz_q;
    rr_d     = rr_q;
    pxsx_d   = pxsx_q;
    pysy_d   = pysy_q;
    zsz_d    = zsz_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    bb_d     = bb_q;
    ac4_d    = ac4_q;
    dis_d    = dis_q;
    shade_d  = shade_q;
`ifndef RT_FAST_SHADE_EN
    cnt_d    = cnt_q;
`endif
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            psx_l_d  = pixel_start_x;
            py_l_d   = pixel_y;
            sx_l_d   = sphere_x;
            sy_l_d   = sphere_y;
            sz_l_d   = sphere_z;
            r_l_d    = sphere_r;
            buffer_d = '0;
            job_d    = '0;
            sph_d    = '0;
            busy_d   = 1'b1;
            state_d  = LOAD;
          end
        end
        LOAD: begin
          px_d    = px_calc;
          py_d    = {{4{py_l_q[11]}}, py_l_q};
          sx_d    = sx_l_q[sph_q*16 +: 16];
          sy_d    = sy_l_q[sph_q*16 +: 16];
          sz_d    = sz_l_q[sph_q*16 +: 16];
          r_d     = r_l_q[sph_q*8 +: 8];
          state_d = CALC1;
        end
        CALC1: begin
          pxx_d   = 32'(px_q) * 32'(px_q);
          pyy_d   = 32'(py_q) * 32'(py_q);
          sxx_d   = 32'(sx_q) * 32'(sx_q);
          syy_d   = 32'(sy_q) * 32'(sy_q);
          szz_d   = 32'(sz_q) * 32'(sz_q);
          rr_d    = $signed({21'd0, r_q, 3'd0}) * $signed({21'd0, r_q, 3'd0});
          pxsx_d  = 32'(px_q) * 32'(sx_q);
          pysy_d  = 32'(py_q) * 32'(sy_q);
          zsz_d   = PIXEL_Z * 32'(sz_q);
          state_d = CALC2;
        end
        CALC2: begin
          a_d     = 36'(pxx_q) + 36'(pyy_q) + PZ2;
          b_d     = (36'(pxsx_q) + 36'(pysy_q) + 36'(zsz_q)) <<< 1;
          c_d     = 36'(sxx_q) + 36'(syy_q) + 36'(szz_q) - 36'(rr_q);
          state_d = CALC3;
        end
        CALC3: begin
          bb_d    = 72'(b_q) * 72'(b_q);
          ac4_d   = (72'(a_q) * 72'(c_q)) <<< 2;
          state_d = CALC4;
        end
        CALC4: begin
          dis_d   = bb_q - ac4_q;
`ifndef RT_FAST_SHADE_EN
          cnt_d   = 8'd0;
`endif
          state_d = SHADE;
        end
        SHADE: begin
`ifdef RT_FAST_SHADE_EN
          if (dis_q[DIS_W-1]) shade_d = '0;
          else if (int'(bitlen) + 1 > SMAX) shade_d = COLOR_W'(SMAX);
          else shade_d = COLOR_W'(int'(bitlen) + 1);
          state_d = NEXT;
`else
          // One bit per cycle; stops early once the count reaches saturation.
          if (dis_q[DIS_W-1]) begin
            shade_d = '0;
            state_d = NEXT;
          end else if (dis_q == '0 || int'(cnt_q) + 1 >= SMAX) begin
            shade_d = COLOR_W'(int'(cnt_q) + 1);
            state_d = NEXT;
          end else begin
            dis_d = dis_q >> 1;
            cnt_d = cnt_q + 8'd1;
          end
`endif
        end
        NEXT: begin
          if (shade_q > cur_shade) buffer_d[job_q*COLOR_W +: COLOR_W] = shade_q;
          if (sph_q == SW'(N_SPHERES - 1)) begin
            sph_d = '0;
            if (job_q == JW'(JOBS_SUBDIVISION - 1)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              job_d   = job_q + 1'b1;
              state_d = LOAD;
            end
          end else begin
            sph_d   = sph_q + 1'b1;
            state_d = LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      buffer_q <= '0;
      job_q    <= '0;
      sph_q    <= '0;
      psx_l_q  <= '0;
      py_l_q   <= '0;
      sx_l_q   <= '0;
      sy_l_q   <= '0;
      sz_l_q   <= '0;
      r_l_q    <= '0;
      px_q     <= '0;
      py_q     <= '0;
      sx_q     <= '0;
      sy_q     <= '0;
      sz_q     <= '0;
      r_q      <= '0;
      pxx_q    <= '0;
      pyy_q    <= '0;
      sxx_q    <= '0;
      syy_q    <= '0;
      szz_q    <= '0;
      rr_q     <= '0;
      pxsx_q   <= '0;
      pysy_q   <= '0;
      zsz_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      bb_q     <= '0;
      ac4_q    <= '0;
      dis_q    <= '0;
      shade_q  <= '0;
`ifndef RT_FAST_SHADE_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      buffer_q <= buffer_d;
      job_q    <= job_d;
      sph_q    <= sph_d;
      psx_l_q  <= psx_l_d;
      py_l_q   <= py_l_d;
      sx_l_q   <= sx_l_d;
      sy_l_q   <= sy_l_d;
      sz_l_q   <= sz_l_d;
      r_l_q    <= r_l_d;
      px_q     <= px_d;
      py_q     <= py_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      sz_q     <= sz_d;
      r_q      <= r_d;
      pxx_q    <= pxx_d;
      pyy_q    <= pyy_d;
      sxx_q    <= sxx_d;
      syy_q    <= syy_d;
      szz_q    <= szz_d;
      rr_q     <= rr_d;
      pxsx_q   <= pxsx_d;
      pysy_q   <= pysy_d;
      zsz_q    <= zsz_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      bb_q     <= bb_d;
      ac4_q    <= ac4_d;
      dis_q    <= dis_d;
      shade_q  <= shade_d;
`ifndef RT_FAST_SHADE_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign buffer = buffer_q;

endmodule

// File: tb/tb_raytracing_worker_ms.sv
// Directed bench: four parameterisations of raytracing_worker_ms with hand-computed shades and latencies.
module tb_raytracing_worker_ms;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, abort;
  logic signed [11:0] psx, py;
  logic [3:0] start;

`ifdef RT_FAST_SHADE_EN
  localparam int LAT_HIT = 7, LAT_MISS = 7, LAT_B = 14, LAT_C = 7, LAT_D = 112, ABORT_AT = 30;
`else
  localparam int LAT_HIT = 35, LAT_MISS = 7, LAT_B = 42, LAT_C = 21, LAT_D = 189, ABORT_AT = 90;
`endif

  logic [15:0] a_sx, a_sy, a_sz; logic [7:0] a_r; logic a_busy, a_done; logic [7:0] a_buf;
  logic [31:0] b_sx, b_sy, b_sz; logic [15:0] b_r; logic b_busy, b_done; logic [7:0] b_buf;
  logic [15:0] c_sx, c_sy, c_sz; logic [7:0] c_r; logic c_busy, c_done; logic [3:0] c_buf;
  logic [31:0] d_sx, d_sy, d_sz; logic [15:0] d_r; logic d_busy, d_done; logic [63:0] d_buf;

  raytracing_worker_ms #(.JOBS_SUBDIVISION(1), .N_SPHERES(1), .COLOR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort), .pixel_start_x(psx), .pixel_y(py),
    .sphere_x(a_sx), .sphere_y(a_sy), .sphere_z(a_sz), .sphere_r(a_r),
    .busy(a_busy), .done(a_done), .buffer(a_buf));
  raytracing_worker_ms #(.JOBS_SUBDIVISION(1), .N_SPHERES(2), .COLOR_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort), .pixel_start_x(psx), .pixel_y(py),
    .sphere_x(b_sx), .sphere_y(b_sy), .sphere_z(b_sz), .sphere_r(b_r),
    .busy(b_busy), .done(b_done), .buffer(b_buf));
  raytracing_worker_ms #(.JOBS_SUBDIVISION(1), .N_SPHERES(1), .COLOR_W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort), .pixel_start_x(psx), .pixel_y(py),
    .sphere_x(c_sx), .sphere_y(c_sy), .sphere_z(c_sz), .sphere_r(c_r),
    .busy(c_busy), .done(c_done), .buffer(c_buf));
  raytracing_worker_ms u_d (
    .clk(clk), .rst_n(rst_n), .start(start[3]), .abort(abort), .pixel_start_x(psx), .pixel_y(py),
    .sphere_x(d_sx), .sphere_y(d_sy), .sphere_z(d_sz), .sphere_r(d_r),
    .busy(d_busy), .done(d_done), .buffer(d_buf));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int i);
    case (i)
      0: return a_done;
      1: return b_done;
      2: return c_done;
      default: return d_done;
    endcase
  endfunction

  task automatic go(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (!get_done(i) && cyc < limit);
  endtask

  initial begin
    int cyc;
    int seen;
    rst_n = 1'b0; abort = 1'b0; start = '0; psx = '0; py = '0;
    a_sx = 16'd0;    a_sy = 16'd0; a_sz = 16'd1000; a_r = 8'd10;
    b_sx = {16'd0, 16'd1000}; b_sy = '0; b_sz = {16'd1000, 16'd1000}; b_r = {8'd10, 8'd10};
    c_sx = 16'd0;    c_sy = 16'd0; c_sz = 16'd1000; c_r = 8'd10;
    d_sx = {16'd1000, 16'd0}; d_sy = '0; d_sz = {16'd1000, 16'd1000}; d_r = {8'd10, 8'd10};
    tick(); tick();
    chk("reset_busy", a_busy, 0);
    chk("reset_done", a_done, 0);
    chk("reset_buf_a", a_buf, 0);
    chk("reset_buf_d", d_buf, 0);

    // First edge with reset released must accept the start.
    rst_n = 1'b1;
    go(0);
    chk("accept_busy", a_busy, 1);
    a_sx = 16'd1000;
    wait_done(0, 200, cyc);
    chk("hit_latency", cyc, LAT_HIT);
    chk("hit_buf", a_buf, 29);
    chk("hit_busy_low", a_busy, 0);
    tick();
    chk("done_one_cycle", a_done, 0);

    go(0);
    wait_done(0, 200, cyc);
    chk("miss_latency", cyc, LAT_MISS);
    chk("miss_buf", a_buf, 0);

    go(1);
    wait_done(1, 200, cyc);
    chk("two_sph_latency", cyc, LAT_B);
    chk("two_sph_max", b_buf, 29);

    go(2);
    wait_done(2, 200, cyc);
    chk("sat_latency", cyc, LAT_C);
    chk("sat_buf", c_buf, 15);

    go(3);
    wait_done(3, 1000, cyc);
    chk("multi_latency", cyc, LAT_D);
    chk("multi_buf", d_buf, 64'h0000_0000_0016_1D1D);
    repeat (5) tick();
    chk("idle_buf_stable", d_buf, 64'h0000_0000_0016_1D1D);

    a_sx = 16'd0;
    go(0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", a_busy, 0);
    seen = 0;
    repeat (60) begin
      tick();
      if (a_done) seen++;
    end
    chk("abort_no_done", seen, 0);

    abort = 1'b1; start[0] = 1'b1;
    tick();
    abort = 1'b0; start[0] = 1'b0;
    chk("abort_start_ignored", a_busy, 0);

    go(3);
    repeat (ABORT_AT - 1) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("mid_abort_busy", d_busy, 0);
    chk("mid_abort_partial", d_buf, 64'h0000_0000_0000_1D1D);
    seen = 0;
    repeat (40) begin
      tick();
      if (d_done) seen++;
    end
    chk("mid_abort_no_done", seen, 0);
    chk("mid_abort_stable", d_buf, 64'h0000_0000_0000_1D1D);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("reset_clears_buf", d_buf, 0);
    chk("reset_clears_busy", d_busy, 0);

    start[0] = 1'b1;
    tick();
    wait_done(0, 200, cyc);
    chk("held_first_latency", cyc, LAT_HIT);
    tick();
    chk("held_restart_busy", a_busy, 1);
    wait_done(0, 200, cyc);
    chk("held_second_latency", cyc + 1, LAT_HIT + 1);
    start[0] = 1'b0;
    tick();
    chk("held_release_busy", a_busy, 0);
    chk("held_release_buf", a_buf, 29);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/raytracing_worker_ms.md
RAYTRACING_WORKER_MS -- requirements
Module: raytracing_worker_ms

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- JOBS_SUBDIVISION, 8, pixels per job.
- N_WORKERS, 4, x stride between successive pixels.
- N_SPHERES, 2, spheres tested per pixel.
- COLOR_W, 8, shade width.
- PIXEL_Z, 100, fixed ray z component.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  job request pulse/level, sampled in IDLE.
- abort  in  1  cancel current job.
- pixel_start_x  in  12 signed  first pixel x.
- pixel_y  in  12 signed  pixel row y.
- sphere_x, sphere_y, sphere_z  in  N_SPHERES×16 signed  packed centres.
- sphere_r  in  N_SPHERES×8 unsigned  packed radii.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- buffer  out  JOBS_SUBDIVISION×COLOR_W  per-pixel shades.
REQ-003 Clock SHALL be clk; reset SHALL be rst_n, synchronous, active-low; no other clock or reset.

Function
REQ-004 FSM states SHALL be IDLE, LOAD, CALC1, CALC2, CALC3, CALC4, SHADE, NEXT.
REQ-005 In IDLE with start=1 and abort=0: latch pixel_start_x, pixel_y and all sphere inputs; clear buffer to 0; job=0, sphere=0; busy=1; go to LOAD.
REQ-006 start while busy=1 SHALL be ignored; inputs are used only from latched copies.
REQ-007 Pixel k x SHALL be pixel_start_x + k*N_WORKERS, computed at 16-bit signed width.
REQ-008 Per (pixel, sphere) pair, the FSM SHALL run LOAD→CALC1→CALC2→CALC3→CALC4, one cycle each, computing:
- a = px²+py²+PIXEL_Z²
- b = 2(px·sx+py·sy+PIXEL_Z·sz)
- c = sx²+sy²+sz² − (r<<3)²
- dis = b² − 4ac
REQ-009 Every intermediate SHALL be full precision with no truncation; dis SHALL be at least 68 bits signed.
REQ-010 Each register SHALL be consumed only in the cycle after it is written; no same-cycle read-after-write of stale values.
REQ-011 Pair shade SHALL be 0 if dis<0, else min(bitlen(dis)+1, 2^COLOR_W−1), where bitlen(0)=0.
REQ-012 buffer[k] SHALL equal the maximum pair shade over all spheres for pixel k, updated in NEXT.
REQ-013 NEXT SHALL advance the sphere index first, then the pixel index. After the last pair, the FSM SHALL go to IDLE, drop busy, and pulse done for one cycle in that IDLE cycle.
REQ-014 Total latency from the start-accept edge to done SHALL be Σ over pairs (6 + S), where S is the SHADE cycle count (REQ-019).
REQ-015 abort=1 in any non-IDLE state SHALL take effect next cycle: IDLE, busy=0, no done, buffer keeps partial values. abort together with start in IDLE SHALL be ignored.
REQ-016 buffer SHALL be stable while busy=0.

Reset
REQ-017 With rst_n=0 at a clk edge: state=IDLE, busy=0, done=0, buffer all 0, indices 0. This SHALL hold mid-job.
REQ-018 The first start SHALL be accepted on the first edge with rst_n=1.

Configuration
REQ-019 Macro RT_FAST_SHADE_EN controls SHADE:
- Defined: shade computed by priority encoder, S=1.
- Undefined: dis shifted right one bit per cycle with shade counting, S=max(shade,1).
Buffer values SHALL be identical in both builds.

Verification
REQ-020 JOBS_SUBDIVISION=1, N_SPHERES=1, px=0, py=0, sphere (0,0,1000,r=10) → dis=256000000, buffer[0]=29; done at 35 cycles (undefined macro) or 7 cycles (defined).
REQ-021 Same setup, sphere (1000,0,1000,r=10) → dis<0, buffer[0]=0, done at 7 cycles.
REQ-022 N_SPHERES=2 with the REQ-021 sphere then the REQ-020 sphere → buffer[0]=29 (maximum selected).
REQ-023 COLOR_W=4 with the REQ-020 sphere → buffer[0]=15 (saturated).
REQ-024 abort asserted 3 cycles after start → busy=0 next cycle, done never pulses; then rst_n=0 for one cycle → buffer all 0.
REQ-025 start held high for the whole job → exactly one job per done; a new job starts on the cycle after done.
